// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle MIPS-lite control sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with a
// variable-latency memory via mem_ready, aborts stalled accesses after
// MEM_TIMEOUT low cycles and counts retired instructions in instret.
// Optional feature: define MC_CTRL_EXC_EN to trap undecoded instructions in
// the EXC state; otherwise they retire as NOPs.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opeCode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             Link,
   output logic             ALUsrc,
   output logic             ALUsign,
   output logic             Mem2Reg,
   output logic [1:0]       ALUop,
   output logic [1:0]       ExtOp,
   output logic [1:0]       PCsrc,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret,
   output logic             mem_timeout,
   output logic             exc_illegal
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_EXC    = 3'd6;

   localparam logic [3:0] K_ADDU  = 4'd0;
   localparam logic [3:0] K_SUBU  = 4'd1;
   localparam logic [3:0] K_SLT   = 4'd2;
   localparam logic [3:0] K_JR    = 4'd3;
   localparam logic [3:0] K_ORI   = 4'd4;
   localparam logic [3:0] K_LW    = 4'd5;
   localparam logic [3:0] K_SW    = 4'd6;
   localparam logic [3:0] K_BEQ   = 4'd7;
   localparam logic [3:0] K_LUI   = 4'd8;
   localparam logic [3:0] K_J     = 4'd9;
   localparam logic [3:0] K_JAL   = 4'd10;
   localparam logic [3:0] K_ADDI  = 4'd11;
   localparam logic [3:0] K_ADDIU = 4'd12;
   localparam logic [3:0] K_BAD   = 4'd15;

   // Wait counter only needs to hold 0..MEM_TIMEOUT-1: expiry clears it.
   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [2:0]    state_next;
   logic [3:0]    kind;
   logic          alu_class;
   logic          mem_wait;
   logic          timeout_hit;
   logic          retire;
   logic [TW-1:0] wait_cnt;

   // Instruction decode into a compact class code.
   always_comb begin
      kind = K_BAD;
      case (opeCode)
         6'h00: begin
            case (funct)
               6'h21:   kind = K_ADDU;
               6'h23:   kind = K_SUBU;
               6'h2a:   kind = K_SLT;
               6'h08:   kind = K_JR;
               default: kind = K_BAD;
            endcase
         end
         6'h0d:   kind = K_ORI;
         6'h23:   kind = K_LW;
         6'h2b:   kind = K_SW;
         6'h04:   kind = K_BEQ;
         6'h0f:   kind = K_LUI;
         6'h02:   kind = K_J;
         6'h03:   kind = K_JAL;
         6'h08:   kind = K_ADDI;
         6'h09:   kind = K_ADDIU;
         default: kind = K_BAD;
      endcase
   end

   assign alu_class = (kind == K_ADDU) || (kind == K_SUBU) || (kind == K_SLT) ||
                      (kind == K_ORI)  || (kind == K_LUI)  || (kind == K_ADDI) ||
                      (kind == K_ADDIU);

   // A completing access in the expiry cycle wins over the timeout.
   assign mem_wait    = (state == S_FETCH) || (state == S_MEM);
   assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready && (wait_cnt == TO_LAST);
   assign mem_timeout = timeout_hit;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (kind != K_BAD) state_next = S_EXEC;
`ifdef MC_CTRL_EXC_EN
            else               state_next = S_EXC;
`else
            else               state_next = S_FETCH;
`endif
         end
         S_EXEC: begin
            if (alu_class)                         state_next = S_WB;
            else if (kind == K_LW || kind == K_SW) state_next = S_MEM;
            else                                   state_next = S_FETCH;
         end
         S_MEM: begin
            if (mem_ready)        state_next = (kind == K_LW) ? S_WB : S_FETCH;
            else if (timeout_hit) state_next = S_FETCH;
            else                  state_next = S_MEM;
         end
         S_WB:     state_next = S_FETCH;
         S_EXC:    state_next = S_FETCH;
         default:  state_next = S_IDLE;
      endcase
   end

   // Datapath enables and selects, decoded from state plus IR fields.
   always_comb begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      Link     = 1'b0;
      ALUsrc   = 1'b0;
      ALUsign  = 1'b0;
      Mem2Reg  = 1'b0;
      ALUop    = 2'b00;
      ExtOp    = 2'b00;
      PCsrc    = 2'b00;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
            end
         end
         S_EXEC: begin
            case (kind)
               K_SUBU:  ALUop = 2'b01;
               K_SLT:   begin ALUop = 2'b11; ALUsign = 1'b1; end
               K_ORI:   begin ALUsrc = 1'b1; ALUop = 2'b10; end
               K_LUI:   begin ALUsrc = 1'b1; ExtOp = 2'b10; end
               K_ADDI:  begin ALUsrc = 1'b1; ExtOp = 2'b01; ALUsign = 1'b1; end
               K_ADDIU: begin ALUsrc = 1'b1; ExtOp = 2'b01; end
               K_LW, K_SW: begin ALUsrc = 1'b1; ExtOp = 2'b01; end
               K_BEQ:   begin ALUop = 2'b01; PCsrc = 2'b01; PCWrite = zero; end
               K_J:     begin PCsrc = 2'b10; PCWrite = 1'b1; end
               K_JAL:   begin PCsrc = 2'b10; PCWrite = 1'b1; RegWrite = 1'b1; Link = 1'b1; end
               K_JR:    begin PCsrc = 2'b11; PCWrite = 1'b1; end
               default: ;
            endcase
         end
         S_MEM: begin
            ALUsrc   = 1'b1;
            ExtOp    = 2'b01;
            MemRead  = (kind == K_LW);
            MemWrite = (kind == K_SW);
         end
         S_WB: begin
            RegWrite = 1'b1;
            RegDst   = (opeCode == 6'h00);
            Mem2Reg  = (kind == K_LW);
         end
         default: ;
      endcase
   end

`ifdef MC_CTRL_EXC_EN
   assign exc_illegal = (state == S_EXC);
   assign retire = (state_next == S_FETCH) &&
                   ((state == S_EXEC) || (state == S_WB) || (state == S_MEM && mem_ready));
`else
   assign exc_illegal = 1'b0;
   assign retire = (state_next == S_FETCH) &&
                   ((state == S_EXEC) || (state == S_WB) || (state == S_DECODE) ||
                    (state == S_MEM && mem_ready));
`endif

   // Memory wait counter: restarts on any state change, completion or expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (!mem_wait || mem_ready || timeout_hit || (state_next != state))
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + TW'(1);
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instret <= '0;
      else if (retire) instret <= instret + CNT_W'(1);
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: instruction-level reference model expands each
// instruction into its expected per-cycle trace; a monitor compares the DUT
// against the queued trace every cycle.
module tb_multicycle_controller;

   localparam int TO = 4;
   localparam int CW = 8;
   localparam int W  = 3 + 16 + 1 + 1 + CW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    opeCode = '0;
   logic [5:0]    funct = '0;
   logic          zero = 1'b0;
   logic          mem_ready = 1'b0;
   logic          PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
   logic          RegDst, Link, ALUsrc, ALUsign, Mem2Reg;
   logic [1:0]    ALUop, ExtOp, PCsrc;
   logic [2:0]    state;
   logic [CW-1:0] instret;
   logic          mem_timeout, exc_illegal;

   typedef struct {
      logic        mr;
      logic        z;
      logic [20:0] e;
      logic        ret;
   } cyc_t;

   cyc_t          plan[$];
   logic [W-1:0]  exp_q[$];
   logic [CW-1:0] model_cnt = '0;
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;

   multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opeCode(opeCode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .Link(Link),
      .ALUsrc(ALUsrc), .ALUsign(ALUsign), .Mem2Reg(Mem2Reg), .ALUop(ALUop),
      .ExtOp(ExtOp), .PCsrc(PCsrc), .state(state), .instret(instret),
      .mem_timeout(mem_timeout), .exc_illegal(exc_illegal)
   );

   // Clock.
   always #5 clk = ~clk;

   // Control word packing: enables, then selects.
   function automatic logic [15:0] mk(input logic pcw, irw, mrd, mwr, rw, rd, lk, as, sg, m2r,
                                      input logic [1:0] aop, eop, ps);
      return {pcw, irw, mrd, mwr, rw, rd, lk, as, sg, m2r, aop, eop, ps};
   endfunction

   function automatic bit legal(input logic [5:0] op, fn);
      case (op)
         6'h00: return (fn == 6'h21) || (fn == 6'h23) || (fn == 6'h2a) || (fn == 6'h08);
         6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h02, 6'h03, 6'h08, 6'h09: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Expected EXEC-cycle controls, as the single-cycle decoder drives them.
   function automatic logic [15:0] exec_ctl(input logic [5:0] op, fn, input logic z);
      case (op)
         6'h00: begin
            case (fn)
               6'h21:   return mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00);
               6'h23:   return mk(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00);
               6'h2a:   return mk(0,0,0,0,0,0,0,0,1,0,2'b11,2'b00,2'b00);
               default: return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11);
            endcase
         end
         6'h0d:   return mk(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,2'b00);
         6'h0f:   return mk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b10,2'b00);
         6'h08:   return mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b01,2'b00);
         6'h09, 6'h23, 6'h2b: return mk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b01,2'b00);
         6'h04:   return mk(z,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b01);
         6'h02:   return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
         default: return mk(1,0,0,0,1,0,1,0,0,0,2'b00,2'b00,2'b10);
      endcase
   endfunction

   task automatic add(input logic mr, z, input logic [2:0] st, input logic [15:0] ctl,
                      input logic mt, ex, ret);
      cyc_t c;
      c.mr  = mr;
      c.z   = z;
      c.e   = {st, ctl, mt, ex};
      c.ret = ret;
      plan.push_back(c);
   endtask

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   // Reference model: expand one instruction into its expected cycle trace.
   // fw/mw = mem_ready-low cycles before completion in FETCH/MEM.
   task automatic build(input logic [5:0] op, fn, input int fw, mw, input logic zr);
      bit ok, is_lw, is_sw, flow, wb;
      int lows;
      ok    = legal(op, fn);
      is_lw = (op == 6'h23);
      is_sw = (op == 6'h2b);
      flow  = (op == 6'h04) || (op == 6'h02) || (op == 6'h03) || (op == 6'h00 && fn == 6'h08);
      wb    = ok && !flow && !is_sw;
      for (int i = 1; i <= fw; i++)
         add(0, rb(), 3'd1, mk(0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00), (i % TO) == 0, 0, 0);
      add(1, rb(), 3'd1, mk(1,1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00), 0, 0, 0);
`ifdef MC_CTRL_EXC_EN
      add(rb(), rb(), 3'd2, 16'd0, 0, 0, 0);
      if (!ok) begin
         add(rb(), rb(), 3'd6, 16'd0, 0, 1, 0);
         return;
      end
`else
      add(rb(), rb(), 3'd2, 16'd0, 0, 0, !ok);
      if (!ok) return;
`endif
      add(rb(), zr, 3'd3, exec_ctl(op, fn, zr), 0, 0, flow);
      if (is_lw || is_sw) begin
         lows = (mw < TO) ? mw : TO;
         for (int i = 1; i <= lows; i++)
            add(0, rb(), 3'd4, mk(0,0,is_lw,is_sw,0,0,0,1,0,0,2'b00,2'b01,2'b00), i == TO, 0, 0);
         if (mw >= TO) return;
         add(1, rb(), 3'd4, mk(0,0,is_lw,is_sw,0,0,0,1,0,0,2'b00,2'b01,2'b00), 0, 0, is_sw);
      end
      if (wb)
         add(rb(), rb(), 3'd5, mk(0,0,0,0,1,op == 6'h00,0,0,0,is_lw,2'b00,2'b00,2'b00), 0, 0, 1);
   endtask

   // Driver: apply up to n planned cycles (n<0: all), queue expectations, drop the rest.
   task automatic play(input int n);
      cyc_t c;
      int k = 0;
      while (plan.size() > 0 && (n < 0 || k < n)) begin
         c = plan.pop_front();
         mem_ready = c.mr;
         zero      = c.z;
         exp_q.push_back({c.e, model_cnt});
         @(posedge clk);
         #1;
         if (c.ret) model_cnt = model_cnt + 1'b1;
         k++;
      end
      plan.delete();
   endtask

   task automatic issue(input logic [5:0] op, fn, input int fw, mw, input logic zr);
      opeCode = op;
      funct   = fn;
      build(op, fn, fw, mw, zr);
      play(-1);
   endtask

   // Reset: asserted asynchronously, held two cycles, then one IDLE cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      model_cnt = '0;
      repeat (2) begin
         mem_ready = rb();
         exp_q.push_back({3'd0, 16'd0, 1'b0, 1'b0, model_cnt});
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      mem_ready = rb();
      exp_q.push_back({3'd0, 16'd0, 1'b0, 1'b0, model_cnt});
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected trace entry per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      logic [W-1:0] act, e;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         act = {state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, Link,
                ALUsrc, ALUsign, Mem2Reg, ALUop, ExtOp, PCsrc, mem_timeout, exc_illegal, instret};
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL trace cycle=%0d got st=%0d ctl=%h mt=%b ex=%b cnt=%0d exp st=%0d ctl=%h mt=%b ex=%b cnt=%0d",
                     cyc, act[W-1 -: 3], act[W-4 -: 16], act[CW+1], act[CW], act[CW-1:0],
                     e[W-1 -: 3], e[W-4 -: 16], e[CW+1], e[CW], e[CW-1:0]);
         end
      end
   end

   // Stimulus.
   initial begin
      logic [5:0] op, fn;
      int fw, mw;
      @(posedge clk);
      #1;
      do_reset();
      // directed cases
      issue(6'h00, 6'h21, 0, 0, 0);   // addu
      issue(6'h23, 6'h00, 0, 2, 0);   // lw, two MEM stall cycles
      issue(6'h04, 6'h00, 0, 0, 0);   // beq not taken
      issue(6'h04, 6'h00, 0, 0, 1);   // beq taken
      issue(6'h03, 6'h00, 0, 0, 0);   // jal
      issue(6'h2b, 6'h00, 0, 6, 0);   // sw, MEM timeout
      issue(6'h3f, 6'h00, 0, 0, 0);   // illegal opcode
      issue(6'h00, 6'h3f, 0, 0, 0);   // illegal funct
      issue(6'h00, 6'h23, 5, 0, 0);   // subu with one FETCH timeout
      issue(6'h2b, 6'h00, 0, 3, 0);   // sw completing in the expiry cycle
      issue(6'h00, 6'h08, 0, 0, 0);   // jr
      issue(6'h00, 6'h2a, 9, 0, 0);   // slt with two FETCH timeouts
      // randomized run, long enough to wrap the 8-bit instret
      for (int n = 0; n < 320; n++) begin
         case ($urandom_range(0, 14))
            0:  begin op = 6'h00; fn = 6'h21; end
            1:  begin op = 6'h00; fn = 6'h23; end
            2:  begin op = 6'h00; fn = 6'h2a; end
            3:  begin op = 6'h00; fn = 6'h08; end
            13: begin op = 6'h00; fn = 6'(32 + $urandom_range(12, 31)); end
            14: begin op = 6'(48 + $urandom_range(0, 15)); fn = 6'($urandom); end
            default: begin
               case ($urandom_range(0, 8))
                  0: op = 6'h0d; 1: op = 6'h23; 2: op = 6'h2b; 3: op = 6'h04;
                  4: op = 6'h0f; 5: op = 6'h02; 6: op = 6'h03; 7: op = 6'h08;
                  default: op = 6'h09;
               endcase
               fn = 6'($urandom);
            end
         endcase
         fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 1);
         mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 1);
         issue(op, fn, fw, mw, rb());
      end
      // reset in the middle of a stalled lw
      opeCode = 6'h23;
      funct   = 6'h00;
      build(6'h23, 6'h00, 0, 3, 0);
      play(4);
      do_reset();
      issue(6'h00, 6'h21, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
